// File: rtl/bin_state_loader_pkg.sv
// Shared definitions for the bin-state loader: FSM encoding, default widths,
// and the one-hot / address helpers used by the loader datapath.
package bin_state_loader_pkg;

    localparam int DEF_WIDTH_VAR_STATES = 19;
    localparam int DEF_WIDTH_LVL_STATES = 11;
    localparam int DEF_WIDTH_LVL        = 16;
    localparam int DEF_WIDTH_BIN_ID     = 10;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_DRAIN,
        LD_DONE,
        UP_WR,
        UP_DONE
    } loader_state_e;

    // Callers truncate the wide result to their own slot count with a size cast.
    function automatic logic [63:0] onehot(input logic [31:0] idx);
        onehot = 64'd1 << idx;
    endfunction

    // Pure bit concatenation {binId, idx}; idx never exceeds idxBits, so no carry.
    function automatic logic [63:0] concatAddr(input logic [31:0] binId,
                                               input logic [31:0] idx,
                                               input int          idxBits);
        concatAddr = ({32'd0, binId} << idxBits) | {32'd0, idx};
    endfunction

endpackage

// File: rtl/bin_state_loader_shifter.sv
// Snapshot register bank for UPDATE: captures the whole state-list bus in one
// cycle and presents the word selected by sel_i.
module state_word_shifter
    import bin_state_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WIDTH_VAR_STATES,
    parameter int COUNT  = 8,
    localparam int SEL_W = $clog2(COUNT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture_i,
    input  logic [WORD_W*COUNT-1:0]   words_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [WORD_W-1:0]         word_o
);

    logic [WORD_W*COUNT-1:0] snap_q;
    logic [WORD_W*COUNT-1:0] snap_d;

    always_comb begin
        snap_d = snap_q;
        if (capture_i) begin
            snap_d = words_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign word_o = snap_q[sel_i*WORD_W +: WORD_W];

endmodule

// File: rtl/bin_state_loader.sv
// Moves one bin's var/lvl states between global bin-state memory and the
// Sat Engine state list (LOAD: memory -> list, UPDATE: list -> memory).
module bin_state_loader
    import bin_state_loader_pkg::*;
#(
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_VAR_STATES = DEF_WIDTH_VAR_STATES,
    parameter int WIDTH_LVL_STATES = DEF_WIDTH_LVL_STATES,
    parameter int WIDTH_LVL        = DEF_WIDTH_LVL,
    parameter int WIDTH_BIN_ID     = DEF_WIDTH_BIN_ID,
    localparam int IDX_W           = $clog2(NUM_VARS),
    localparam int WIDTH_ADDR      = WIDTH_BIN_ID + IDX_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_load_i,
    input  logic                                   start_update_i,
    input  logic [WIDTH_BIN_ID-1:0]                bin_id_i,
    input  logic [WIDTH_LVL-1:0]                   base_lvl_i,
    output logic                                   busy_o,
    output logic                                   done_load_o,
    output logic                                   done_update_o,
    output logic                                   mem_vs_rd_en_o,
    output logic                                   mem_vs_wr_en_o,
    output logic [WIDTH_ADDR-1:0]                  mem_vs_addr_o,
    output logic [WIDTH_VAR_STATES-1:0]            mem_vs_wdata_o,
    input  logic [WIDTH_VAR_STATES-1:0]            mem_vs_rdata_i,
    output logic                                   mem_ls_rd_en_o,
    output logic                                   mem_ls_wr_en_o,
    output logic [WIDTH_ADDR-1:0]                  mem_ls_addr_o,
    output logic [WIDTH_LVL_STATES-1:0]            mem_ls_wdata_o,
    input  logic [WIDTH_LVL_STATES-1:0]            mem_ls_rdata_i,
    output logic [NUM_VARS-1:0]                    wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_i,
    output logic [NUM_LVLS-1:0]                    wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_i,
    output logic                                   base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                   base_lvl_o,
    output logic                                   load_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                   load_lvl_o
);

    loader_state_e           state_q,    state_d;
    logic [IDX_W-1:0]        idx_q,      idx_d;
    logic [WIDTH_BIN_ID-1:0] binId_q,    binId_d;
    logic [WIDTH_LVL-1:0]    baseLvl_q,  baseLvl_d;
    logic                    validDly_q, validDly_d;
    logic [IDX_W-1:0]        idxDly_q,   idxDly_d;

    logic                        acceptLoad;
    logic                        acceptUpdate;
    logic                        lastIdx;
    logic [WIDTH_ADDR-1:0]       addr;
    logic [NUM_VARS-1:0]         retSelVar;
    logic [NUM_LVLS-1:0]         retSelLvl;
    logic [WIDTH_VAR_STATES-1:0] snapVar;
    logic [WIDTH_LVL_STATES-1:0] snapLvl;

    // Update takes priority when both starts land in the same IDLE cycle.
    assign acceptUpdate = (state_q == IDLE) && start_update_i;
    assign acceptLoad   = (state_q == IDLE) && start_load_i && !start_update_i;
    assign lastIdx      = (idx_q == IDX_W'(NUM_VARS - 1));
    assign addr         = WIDTH_ADDR'(concatAddr(32'(binId_q), 32'(idx_q), IDX_W));
    assign retSelVar    = NUM_VARS'(onehot(32'(idxDly_q)));
    assign retSelLvl    = NUM_LVLS'(onehot(32'(idxDly_q)));

    state_word_shifter #(
        .WORD_W (WIDTH_VAR_STATES),
        .COUNT  (NUM_VARS)
    ) u_var_snapshot (
        .clk       (clk),
        .rst       (rst),
        .capture_i (acceptUpdate),
        .words_i   (vars_states_i),
        .sel_i     (idx_q),
        .word_o    (snapVar)
    );

    state_word_shifter #(
        .WORD_W (WIDTH_LVL_STATES),
        .COUNT  (NUM_LVLS)
    ) u_lvl_snapshot (
        .clk       (clk),
        .rst       (rst),
        .capture_i (acceptUpdate),
        .words_i   (lvl_states_i),
        .sel_i     (idx_q),
        .word_o    (snapLvl)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        binId_d    = binId_q;
        baseLvl_d  = baseLvl_q;
        validDly_d = (state_q == LD_RD);
        idxDly_d   = idx_q;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (acceptUpdate) begin
                    state_d = UP_WR;
                    binId_d = bin_id_i;
                end else if (acceptLoad) begin
                    state_d   = LD_RD;
                    binId_d   = bin_id_i;
                    baseLvl_d = base_lvl_i;
                end
            end
            LD_RD: begin
                idx_d = idx_q + 1'b1;
                if (lastIdx) begin
                    state_d = LD_DRAIN;
                end
            end
            LD_DRAIN: state_d = LD_DONE;
            LD_DONE:  state_d = IDLE;
            UP_WR: begin
                idx_d = idx_q + 1'b1;
                if (lastIdx) begin
                    state_d = UP_DONE;
                end
            end
            UP_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            binId_q    <= '0;
            baseLvl_q  <= '0;
            validDly_q <= 1'b0;
            idxDly_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            binId_q    <= binId_d;
            baseLvl_q  <= baseLvl_d;
            validDly_q <= validDly_d;
            idxDly_q   <= idxDly_d;
        end
    end

    // Data buses are zeroed whenever their enable is low so idle outputs are deterministic.
    always_comb begin
        busy_o          = (state_q != IDLE);
        done_load_o     = 1'b0;
        done_update_o   = 1'b0;
        mem_vs_rd_en_o  = 1'b0;
        mem_vs_wr_en_o  = 1'b0;
        mem_vs_addr_o   = '0;
        mem_vs_wdata_o  = '0;
        mem_ls_rd_en_o  = 1'b0;
        mem_ls_wr_en_o  = 1'b0;
        mem_ls_addr_o   = '0;
        mem_ls_wdata_o  = '0;
        wr_var_states_o = '0;
        vars_states_o   = '0;
        wr_lvl_states_o = '0;
        lvl_states_o    = '0;
        base_lvl_en_o   = 1'b0;
        base_lvl_o      = '0;
        load_lvl_en_o   = 1'b0;
        load_lvl_o      = '0;

        case (state_q)
            LD_RD: begin
                mem_vs_rd_en_o = 1'b1;
                mem_ls_rd_en_o = 1'b1;
                mem_vs_addr_o  = addr;
                mem_ls_addr_o  = addr;
            end
            LD_DONE: begin
                done_load_o   = 1'b1;
                base_lvl_en_o = 1'b1;
                load_lvl_en_o = 1'b1;
                base_lvl_o    = baseLvl_q;
                load_lvl_o    = baseLvl_q;
            end
            UP_WR: begin
                mem_vs_wr_en_o = 1'b1;
                mem_ls_wr_en_o = 1'b1;
                mem_vs_addr_o  = addr;
                mem_ls_addr_o  = addr;
                mem_vs_wdata_o = snapVar;
                mem_ls_wdata_o = snapLvl;
            end
            UP_DONE: done_update_o = 1'b1;
            default: ;
        endcase

        // Read data returns one cycle after its strobe; idxDly_q picks the slot.
        if (validDly_q) begin
            wr_var_states_o = retSelVar;
            wr_lvl_states_o = retSelLvl;
            vars_states_o   = {NUM_VARS{mem_vs_rdata_i}};
            lvl_states_o    = {NUM_LVLS{mem_ls_rdata_i}};
        end
    end

endmodule

// File: tb/tb_bin_state_loader.sv
// Self-checking bench for bin_state_loader: a cycle-level expectation model
// plus a bin-state memory, driven with directed and randomized operations.
module tb_bin_state_loader;

    localparam int N  = 8;
    localparam int WV = 19;
    localparam int WL = 11;
    localparam int WA = 13;
    localparam int OP_IDLE   = 0;
    localparam int OP_LOAD   = 1;
    localparam int OP_UPDATE = 2;

    logic              clk;
    logic              rst;
    logic              start_load_i;
    logic              start_update_i;
    logic [9:0]        bin_id_i;
    logic [15:0]       base_lvl_i;
    logic              busy_o, done_load_o, done_update_o;
    logic              mem_vs_rd_en_o, mem_vs_wr_en_o;
    logic [WA-1:0]     mem_vs_addr_o;
    logic [WV-1:0]     mem_vs_wdata_o, mem_vs_rdata_i;
    logic              mem_ls_rd_en_o, mem_ls_wr_en_o;
    logic [WA-1:0]     mem_ls_addr_o;
    logic [WL-1:0]     mem_ls_wdata_o, mem_ls_rdata_i;
    logic [N-1:0]      wr_var_states_o, wr_lvl_states_o;
    logic [WV*N-1:0]   vars_states_o, vars_states_i;
    logic [WL*N-1:0]   lvl_states_o, lvl_states_i;
    logic              base_lvl_en_o, load_lvl_en_o;
    logic [15:0]       base_lvl_o, load_lvl_o;

    typedef struct packed {
        logic            busy;
        logic            doneLoad;
        logic            doneUpdate;
        logic            vsRd;
        logic            vsWr;
        logic [WA-1:0]   vsAddr;
        logic [WV-1:0]   vsWdata;
        logic            lsRd;
        logic            lsWr;
        logic [WA-1:0]   lsAddr;
        logic [WL-1:0]   lsWdata;
        logic [N-1:0]    wrVar;
        logic [WV*N-1:0] varsOut;
        logic [N-1:0]    wrLvl;
        logic [WL*N-1:0] lvlOut;
        logic            baseEn;
        logic [15:0]     baseLvl;
        logic            loadEn;
        logic [15:0]     loadLvl;
    } outs_t;

    outs_t act;
    outs_t e;
    int    nChecks = 0;
    int    nFails  = 0;

    // Physical memory written by the DUT, and the reference contents the model expects.
    logic [WV-1:0] vsMem [0:(1<<WA)-1];
    logic [WL-1:0] lsMem [0:(1<<WA)-1];
    logic [WV-1:0] refVs [0:(1<<WA)-1];
    logic [WL-1:0] refLs [0:(1<<WA)-1];
    logic [WV-1:0] expV [0:N-1];
    logic [WL-1:0] expL [0:N-1];

    bin_state_loader dut (
        .clk             (clk),
        .rst             (rst),
        .start_load_i    (start_load_i),
        .start_update_i  (start_update_i),
        .bin_id_i        (bin_id_i),
        .base_lvl_i      (base_lvl_i),
        .busy_o          (busy_o),
        .done_load_o     (done_load_o),
        .done_update_o   (done_update_o),
        .mem_vs_rd_en_o  (mem_vs_rd_en_o),
        .mem_vs_wr_en_o  (mem_vs_wr_en_o),
        .mem_vs_addr_o   (mem_vs_addr_o),
        .mem_vs_wdata_o  (mem_vs_wdata_o),
        .mem_vs_rdata_i  (mem_vs_rdata_i),
        .mem_ls_rd_en_o  (mem_ls_rd_en_o),
        .mem_ls_wr_en_o  (mem_ls_wr_en_o),
        .mem_ls_addr_o   (mem_ls_addr_o),
        .mem_ls_wdata_o  (mem_ls_wdata_o),
        .mem_ls_rdata_i  (mem_ls_rdata_i),
        .wr_var_states_o (wr_var_states_o),
        .vars_states_o   (vars_states_o),
        .vars_states_i   (vars_states_i),
        .wr_lvl_states_o (wr_lvl_states_o),
        .lvl_states_o    (lvl_states_o),
        .lvl_states_i    (lvl_states_i),
        .base_lvl_en_o   (base_lvl_en_o),
        .base_lvl_o      (base_lvl_o),
        .load_lvl_en_o   (load_lvl_en_o),
        .load_lvl_o      (load_lvl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with one-cycle read latency; garbage is returned when not reading.
    always @(posedge clk) begin
        mem_vs_rdata_i <= mem_vs_rd_en_o ? vsMem[mem_vs_addr_o] : WV'($urandom);
        mem_ls_rdata_i <= mem_ls_rd_en_o ? lsMem[mem_ls_addr_o] : WL'($urandom);
        if (mem_vs_wr_en_o) vsMem[mem_vs_addr_o] <= mem_vs_wdata_o;
        if (mem_ls_wr_en_o) lsMem[mem_ls_addr_o] <= mem_ls_wdata_o;
    end

    always_comb begin
        act.busy       = busy_o;
        act.doneLoad   = done_load_o;
        act.doneUpdate = done_update_o;
        act.vsRd       = mem_vs_rd_en_o;
        act.vsWr       = mem_vs_wr_en_o;
        act.vsAddr     = mem_vs_addr_o;
        act.vsWdata    = mem_vs_wdata_o;
        act.lsRd       = mem_ls_rd_en_o;
        act.lsWr       = mem_ls_wr_en_o;
        act.lsAddr     = mem_ls_addr_o;
        act.lsWdata    = mem_ls_wdata_o;
        act.wrVar      = wr_var_states_o;
        act.varsOut    = vars_states_o;
        act.wrLvl      = wr_lvl_states_o;
        act.lvlOut     = lvl_states_o;
        act.baseEn     = base_lvl_en_o;
        act.baseLvl    = base_lvl_o;
        act.loadEn     = load_lvl_en_o;
        act.loadLvl    = load_lvl_o;
    end

    // Expected outputs c cycles after a start pulse (cycle 0 = start cycle).
    function automatic outs_t model(input int kind, input int c, input int bin, input logic [15:0] base);
        outs_t m;
        int    a;
        m = '0;
        if (kind == OP_LOAD) begin
            if (c >= 1 && c <= N + 2) m.busy = 1'b1;
            if (c >= 1 && c <= N) begin
                a        = bin * N + (c - 1);
                m.vsRd   = 1'b1;
                m.lsRd   = 1'b1;
                m.vsAddr = WA'(a);
                m.lsAddr = WA'(a);
            end
            if (c >= 2 && c <= N + 1) begin
                a       = bin * N + (c - 2);
                m.wrVar = N'(1 << (c - 2));
                m.wrLvl = N'(1 << (c - 2));
                for (int i = 0; i < N; i++) begin
                    m.varsOut[i*WV +: WV] = refVs[a];
                    m.lvlOut[i*WL +: WL]  = refLs[a];
                end
            end
            if (c == N + 2) begin
                m.doneLoad = 1'b1;
                m.baseEn   = 1'b1;
                m.loadEn   = 1'b1;
                m.baseLvl  = base;
                m.loadLvl  = base;
            end
        end else if (kind == OP_UPDATE) begin
            if (c >= 1 && c <= N + 1) m.busy = 1'b1;
            if (c >= 1 && c <= N) begin
                a         = bin * N + (c - 1);
                m.vsWr    = 1'b1;
                m.lsWr    = 1'b1;
                m.vsAddr  = WA'(a);
                m.lsAddr  = WA'(a);
                m.vsWdata = expV[c - 1];
                m.lsWdata = expL[c - 1];
            end
            if (c == N + 1) m.doneUpdate = 1'b1;
        end
        return m;
    endfunction

    task automatic drive_states();
        for (int i = 0; i < N; i++) begin
            vars_states_i[i*WV +: WV] = expV[i];
            lvl_states_i[i*WL +: WL]  = expL[i];
        end
    endtask

    task automatic commit_update(input int bin);
        for (int i = 0; i < N; i++) begin
            refVs[bin*N + i] = expV[i];
            refLs[bin*N + i] = expL[i];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 3) rst = 1'b0;
            e = model(OP_IDLE, c, 0, '0);
            nChecks++;
            if (act !== e) begin
                nFails++;
                $display("[TB] FAIL reset c=%0d: got %h want %h", c, act, e);
            end
        end
    endtask

    task automatic test_load_basic();
        for (int c = 0; c <= N + 2; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                start_load_i = 1'b1; bin_id_i = 10'd3; base_lvl_i = 16'd5;
            end else begin
                start_load_i = 1'b0; bin_id_i = '0; base_lvl_i = '0;
            end
            e = model(OP_LOAD, c, 3, 16'd5);
            nChecks++;
            if (act !== e) begin
                nFails++;
                $display("[TB] FAIL load_basic c=%0d: got %h want %h", c, act, e);
            end
        end
    endtask

    task automatic test_update_snapshot();
        for (int i = 0; i < N; i++) begin
            expV[i] = WV'(i + 1);
            expL[i] = WL'($urandom);
        end
        for (int c = 0; c <= N + 1; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                drive_states();
                start_update_i = 1'b1; bin_id_i = 10'd7;
            end else begin
                start_update_i = 1'b0; bin_id_i = '0;
            end
            if (c == 2) begin
                vars_states_i = {N{WV'($urandom)}};
                lvl_states_i  = {N{WL'($urandom)}};
            end
            e = model(OP_UPDATE, c, 7, '0);
            nChecks++;
            if (act !== e) begin
                nFails++;
                $display("[TB] FAIL update_snapshot c=%0d: got %h want %h", c, act, e);
            end
        end
        commit_update(7);
    endtask

    task automatic test_simultaneous();
        int          bin  = int'($urandom_range(0, 1023));
        logic [15:0] base = 16'($urandom);
        for (int i = 0; i < N; i++) begin
            expV[i] = WV'($urandom);
            expL[i] = WL'($urandom);
        end
        for (int c = 0; c <= N + 1; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                drive_states();
                start_load_i = 1'b1; start_update_i = 1'b1;
                bin_id_i = 10'(bin); base_lvl_i = base;
            end else begin
                start_load_i = 1'b0; start_update_i = 1'b0;
            end
            e = model(OP_UPDATE, c, bin, '0);
            nChecks++;
            if (act !== e) begin
                nFails++;
                $display("[TB] FAIL simultaneous c=%0d: got %h want %h", c, act, e);
            end
        end
        commit_update(bin);
    endtask

    task automatic test_ignore_busy_start();
        logic [15:0] base = 16'($urandom);
        for (int c = 0; c <= N + 2; c++) begin
            @(posedge clk); #1;
            start_load_i   = (c == 0) || (c == 4);
            start_update_i = (c == 6);
            bin_id_i       = (c == 0) ? 10'd12 : 10'd5;
            base_lvl_i     = (c == 0) ? base : 16'd99;
            e = model(OP_LOAD, c, 12, base);
            nChecks++;
            if (act !== e) begin
                nFails++;
                $display("[TB] FAIL ignore_busy_start c=%0d: got %h want %h", c, act, e);
            end
        end
        start_update_i = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int          bin  = int'($urandom_range(0, 1023));
        logic [15:0] base = 16'($urandom);
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk); #1;
            start_load_i = (c == 0);
            bin_id_i     = 10'(bin);
            base_lvl_i   = base;
            rst          = (c == 5);
            e = model((c <= 5) ? OP_LOAD : OP_IDLE, c, bin, base);
            nChecks++;
            if (act !== e) begin
                nFails++;
                $display("[TB] FAIL reset_mid_load c=%0d: got %h want %h", c, act, e);
            end
        end
        bin  = int'($urandom_range(0, 1023));
        base = 16'($urandom);
        for (int c = 0; c <= N + 2; c++) begin
            @(posedge clk); #1;
            start_load_i = (c == 0);
            bin_id_i     = 10'(bin);
            base_lvl_i   = base;
            e = model(OP_LOAD, c, bin, base);
            nChecks++;
            if (act !== e) begin
                nFails++;
                $display("[TB] FAIL load_after_reset c=%0d: got %h want %h", c, act, e);
            end
        end
    endtask

    // Load, update and reload bin 1023 with each start in the cycle after the previous done.
    task automatic test_max_bin_back_to_back();
        logic [15:0] base = 16'($urandom);
        for (int i = 0; i < N; i++) begin
            expV[i] = WV'($urandom);
            expL[i] = WL'($urandom);
        end
        for (int step = 0; step < 3; step++) begin
            int kind = (step == 1) ? OP_UPDATE : OP_LOAD;
            int last = (kind == OP_LOAD) ? N + 2 : N + 1;
            for (int c = 0; c <= last; c++) begin
                @(posedge clk); #1;
                if (c == 0) drive_states();
                start_load_i   = (c == 0) && (kind == OP_LOAD);
                start_update_i = (c == 0) && (kind == OP_UPDATE);
                bin_id_i       = 10'd1023;
                base_lvl_i     = base;
                e = model(kind, c, 1023, base);
                nChecks++;
                if (act !== e) begin
                    nFails++;
                    $display("[TB] FAIL max_bin step=%0d c=%0d: got %h want %h", step, c, act, e);
                end
                if (c == N && kind == OP_LOAD) begin
                    nChecks++;
                    if (mem_vs_addr_o !== 13'h1FFF) begin
                        nFails++;
                        $display("[TB] FAIL max_bin_last_addr: got %h want 1fff", mem_vs_addr_o);
                    end
                end
            end
            if (kind == OP_UPDATE) commit_update(1023);
        end
    endtask

    task automatic test_random();
        int lastBin = 7;
        for (int op = 0; op < 10; op++) begin
            int          kind = ($urandom_range(0, 1) == 1) ? OP_UPDATE : OP_LOAD;
            int          bin  = ($urandom_range(0, 1) == 1) ? lastBin : int'($urandom_range(0, 1023));
            int          last = (kind == OP_LOAD) ? N + 2 : N + 1;
            int          gap  = int'($urandom_range(0, 2));
            logic [15:0] base = 16'($urandom);
            for (int i = 0; i < N; i++) begin
                expV[i] = WV'($urandom);
                expL[i] = WL'($urandom);
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                e = model(OP_IDLE, 0, 0, '0);
                nChecks++;
                if (act !== e) begin
                    nFails++;
                    $display("[TB] FAIL random_gap op=%0d: got %h want %h", op, act, e);
                end
            end
            for (int c = 0; c <= last; c++) begin
                @(posedge clk); #1;
                if (c == 0) drive_states();
                else if (c == 3) begin
                    vars_states_i = {N{WV'($urandom)}};
                    lvl_states_i  = {N{WL'($urandom)}};
                end
                start_load_i   = (c == 0) && (kind == OP_LOAD);
                start_update_i = (c == 0) && (kind == OP_UPDATE);
                bin_id_i       = (c == 0) ? 10'(bin) : 10'($urandom);
                base_lvl_i     = (c == 0) ? base : 16'($urandom);
                e = model(kind, c, bin, base);
                nChecks++;
                if (act !== e) begin
                    nFails++;
                    $display("[TB] FAIL random op=%0d kind=%0d c=%0d: got %h want %h", op, kind, c, act, e);
                end
            end
            if (kind == OP_UPDATE) begin
                commit_update(bin);
                lastBin = bin;
            end
        end
        @(posedge clk); #1;
        e = model(OP_IDLE, 0, 0, '0);
        nChecks++;
        if (act !== e) begin
            nFails++;
            $display("[TB] FAIL final_idle: got %h want %h", act, e);
        end
    endtask

    initial begin
        rst            = 1'b1;
        start_load_i   = 1'b0;
        start_update_i = 1'b0;
        bin_id_i       = '0;
        base_lvl_i     = '0;
        vars_states_i  = '0;
        lvl_states_i   = '0;
        for (int a = 0; a < (1 << WA); a++) begin
            vsMem[a] = WV'(256 * (a / N) + (a % N));
            refVs[a] = WV'(256 * (a / N) + (a % N));
            lsMem[a] = WL'(a * 37 + 5);
            refLs[a] = WL'(a * 37 + 5);
        end
        test_reset();
        test_load_basic();
        test_update_snapshot();
        test_simultaneous();
        test_ignore_busy_start();
        test_reset_mid_load();
        test_max_bin_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
